// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage. Owns the program counter, drives the
// instruction-memory byte address, registers the returned word into the IF/ID
// register with a valid/ready handshake, applies decode-resolved redirects and
// halts once the PC runs past the end of the program.
module pc_fetch_unit #(
    parameter int unsigned PROG_WORDS = 17,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        decode_ready,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic        halted
);

    localparam logic [31:0] END_ADDR = 32'(PROG_WORDS * 4);

    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic [31:0] branch_disp;
    logic [31:0] redirect_pc;
    logic        consume;
    logic        redirect;
    logic        adv;

    assign pc_out = pc;
    assign halted = (pc >= END_ADDR);

    // Handshake qualifiers and redirect target, all relative to the word held in IF/ID.
    always_comb begin
        seq_pc      = fetch_pc + 32'd4;
        branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        redirect_pc = jump ? {seq_pc[31:28], jump_target, 2'b00}
                           : seq_pc + branch_disp;
        consume     = fetch_valid & decode_ready;
        redirect    = consume & (jump | branch_taken);
        adv         = ~halted & ~stall & (~fetch_valid | decode_ready) & ~redirect;
    end

    // PC and IF/ID register: redirect squashes, adv fetches, drain retires the last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            fetch_instr <= 32'h0;
            fetch_pc    <= 32'h0;
            fetch_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_pc;
            fetch_valid <= 1'b0;
        end else if (adv) begin
            fetch_instr <= instr_in;
            fetch_pc    <= pc;
            fetch_valid <= 1'b1;
            pc          <= pc + 32'd4;
        end else if (consume) begin
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven check of pc_fetch_unit with a scoreboard queue.
module tb_pc_fetch_unit;

    typedef struct {
        logic        rst_before;
        logic        stall;
        logic        ready;
        logic        br;
        logic [15:0] off;
        logic        jmp;
        logic [25:0] jt;
        logic [31:0] pc;
        logic [31:0] fpc;
        logic        fv;
        logic        hlt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] fpc;
        logic [31:0] fi;
        logic        fv;
        logic        hlt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        decode_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        halted;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    pc_fetch_unit #(.PROG_WORDS(17), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_out       (pc_out),
        .instr_in     (instr_in),
        .stall        (stall),
        .decode_ready (decode_ready),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .halted       (halted)
    );

    // Instruction memory model: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    assign instr_in = mem_word(pc_out);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic add(input logic rb, input logic st, input logic rd, input logic br,
                       input logic [15:0] off, input logic jm, input logic [25:0] jt,
                       input logic [31:0] epc, input logic [31:0] efpc,
                       input logic efv, input logic ehlt);
        vec_t v;
        v.rst_before = rb; v.stall = st; v.ready = rd; v.br = br; v.off = off;
        v.jmp = jm; v.jt = jt; v.pc = epc; v.fpc = efpc; v.fv = efv; v.hlt = ehlt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (pc_out !== e.pc) begin
            n_bad++;
            $display("FAIL %s pc_out: got %h want %h", name, pc_out, e.pc);
        end
        if (fetch_pc !== e.fpc) begin
            n_bad++;
            $display("FAIL %s fetch_pc: got %h want %h", name, fetch_pc, e.fpc);
        end
        if (fetch_instr !== e.fi) begin
            n_bad++;
            $display("FAIL %s fetch_instr: got %h want %h", name, fetch_instr, e.fi);
        end
        if (fetch_valid !== e.fv) begin
            n_bad++;
            $display("FAIL %s fetch_valid: got %b want %b", name, fetch_valid, e.fv);
        end
        if (halted !== e.hlt) begin
            n_bad++;
            $display("FAIL %s halted: got %b want %b", name, halted, e.hlt);
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic apply(input int idx);
        exp_t e;
        exp_t got;
        vec_t v;
        v = vecs[idx];
        stall = v.stall; decode_ready = v.ready; branch_taken = v.br;
        branch_offset = v.off; jump = v.jmp; jump_target = v.jt;
        e.pc = v.pc; e.fpc = v.fpc; e.fv = v.fv; e.hlt = v.hlt; e.fi = mem_word(v.fpc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL vec%0d scoreboard empty", idx);
        end else begin
            got = exp_q.pop_front();
            check($sformatf("vec%0d", idx), got);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; decode_ready = 1'b1; branch_taken = 1'b0;
        branch_offset = 16'h0; jump = 1'b0; jump_target = 26'h0;
    endtask

    initial begin
        exp_t rz;
        n_vec = 0;
        n_bad = 0;
        rz.pc = 32'h0; rz.fpc = 32'h0; rz.fi = 32'h0; rz.fv = 1'b0; rz.hlt = 1'b0;

        // Straight-line fetch from reset.
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h04, 32'h00, 1, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h08, 32'h04, 1, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h0C, 32'h08, 1, 0);
        // Decode back-pressure for three cycles.
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 0, 16'h0, 0, 26'h0, 32'h0C, 32'h08, 1, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h10, 32'h0C, 1, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h14, 32'h10, 1, 0);
        // Jump at fetch_pc 0x10 to word 3.
        add(0, 0, 1, 0, 16'h0, 1, 26'h3, 32'h0C, 32'h10, 0, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h10, 32'h0C, 1, 0);
        for (int k = 1; k <= 11; k++)
            add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'(32'h0C + 4 * k + 4), 32'(32'h0C + 4 * k), 1, 0);
        // Backward branch at 0x38.
        add(0, 0, 1, 1, 16'hFFF7, 0, 26'h0, 32'h18, 32'h38, 0, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h1C, 32'h18, 1, 0);
        // Branch under stall is still taken; then stall alone holds / drains.
        add(0, 1, 1, 1, 16'h0002, 0, 26'h0, 32'h24, 32'h18, 0, 0);
        add(0, 1, 1, 0, 16'h0, 0, 26'h0, 32'h24, 32'h18, 0, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h28, 32'h24, 1, 0);
        add(0, 1, 1, 0, 16'h0, 0, 26'h0, 32'h28, 32'h24, 0, 0);
        add(0, 1, 0, 0, 16'h0, 0, 26'h0, 32'h28, 32'h24, 0, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h2C, 32'h28, 1, 0);
        // Run into the halt boundary.
        for (int k = 1; k <= 6; k++)
            add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'(32'h28 + 4 * k + 4), 32'(32'h28 + 4 * k), 1,
                (32'h28 + 4 * k + 4) >= 32'h44);
        add(0, 0, 0, 0, 16'h0, 0, 26'h0, 32'h44, 32'h40, 1, 1);
        // Backward branch in the last word un-halts.
        add(0, 0, 1, 1, 16'hFFF2, 0, 26'h0, 32'h0C, 32'h40, 0, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h10, 32'h0C, 1, 0);
        for (int k = 1; k <= 13; k++)
            add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'(32'h0C + 4 * k + 4), 32'(32'h0C + 4 * k), 1,
                (32'h0C + 4 * k + 4) >= 32'h44);
        // Fall-through: drain, then stay halted; a branch with no valid word is ignored.
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h44, 32'h40, 0, 1);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h44, 32'h40, 0, 1);
        add(0, 0, 1, 1, 16'hFFF2, 0, 26'h0, 32'h44, 32'h40, 0, 1);
        // Asynchronous reset while halted, then again with a word in flight.
        add(1, 0, 1, 0, 16'h0, 0, 26'h0, 32'h04, 32'h00, 1, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h08, 32'h04, 1, 0);
        add(1, 0, 1, 0, 16'h0, 0, 26'h0, 32'h04, 32'h00, 1, 0);
        add(0, 0, 1, 0, 16'h0, 0, 26'h0, 32'h08, 32'h04, 1, 0);

        idle_inputs();
        reset = 1'b0;
        #1 reset = 1'b1;
        #2 check("reset", rz);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) begin
                #2 reset = 1'b1;
                #1 check($sformatf("async_reset%0d", i), rz);
                @(negedge clk);
                reset = 1'b0;
            end
            apply(i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
